pattern_stream_gen: RTL and testbench

Upstream bit source for the sequence-detector FSM: captures a PAT_W-bit pattern from the switches and, on each debounced press of a raw pushbutton, presents the next bit (MSB first) on `w` together with a one-cycle `w_valid` strobe. The detector consumes `w` and uses `w_valid` as its state-advance enable. This removes the bouncy KEY-as-clock arrangement: the whole path runs on the board clock.

---
 rtl/pattern_stream_gen_pkg.sv | 15 +
 rtl/key_debounce.sv | 45 ++++
 rtl/pattern_stream_gen.sv | 86 ++++++++
 tb/tb_pattern_stream_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_stream_gen_pkg.sv
// Shared definitions for the pattern stream generator: FSM state encoding and the
// bits_left width helper, used by the top and its key debouncer.
package pattern_stream_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int bits_left_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF sync -> debounced level -> one-cycle press pulse on 1->0.
// Press is registered DB_CYCLES+2 edges after the raw fall; no backpressure, release is silent.
module key_debounce
  import pattern_stream_gen_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any cycle agreeing with the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_stream_gen.sv
// Streams a loaded PAT_W-bit pattern MSB first, one bit per debounced key press.
// w/w_valid update one edge after the internal press; load beats a same-cycle press.
module pattern_stream_gen
  import pattern_stream_gen_pkg::*;
#(
  parameter int PAT_W     = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          step_btn,
  input  logic                          load,
  input  logic [PAT_W-1:0]              pattern,
  output logic                          w,
  output logic                          w_valid,
  output logic [bits_left_w(PAT_W)-1:0] bits_left,
  output logic                          busy,
  output logic                          done
);

  localparam int BLW = bits_left_w(PAT_W);

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] shreg;
  logic [PAT_W-1:0] shreg_nxt;
  logic [BLW-1:0]   left_nxt;
  logic             w_nxt;
  logic             w_valid_nxt;
  logic             press;

  key_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_key_debounce (
    .Clock (Clock),
    .Reset (Reset),
    .btn_n (step_btn),
    .press (press)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bits_left <= '0;
      w         <= 1'b0;
      w_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bits_left <= left_nxt;
      w         <= w_nxt;
      w_valid   <= w_valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    left_nxt    = bits_left;
    w_nxt       = w;
    w_valid_nxt = 1'b0;
    if (load) begin
      shreg_nxt = pattern;
      left_nxt  = BLW'(PAT_W);
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (press) begin
            w_nxt       = shreg[PAT_W-1];
            shreg_nxt   = {shreg[PAT_W-2:0], 1'b0};
            left_nxt    = bits_left - BLW'(1);
            w_valid_nxt = 1'b1;
            if (bits_left == BLW'(1)) state_nxt = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Randomised and directed stimulus for pattern_stream_gen, checked every cycle
// against a queue-based model of the key path and bit stream.
module tb_pattern_stream_gen;

  localparam int PAT_W = 8;
  localparam int DB    = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       step_btn;
  logic       load;
  logic [7:0] pattern;
  logic       w;
  logic       w_valid;
  logic [3:0] bits_left;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  // Model: raw key delayed two cycles, level flips once the last DB delayed
  // samples all disagree with it; the stream is a queue of pending bits.
  bit m_s1, m_s2, m_lvl, m_press, m_w, m_wv;
  int m_phase;  // 0 idle, 1 run, 2 done
  bit m_q[$];
  bit m_hist[$];
  bit seen[$];

  pattern_stream_gen #(
    .PAT_W(PAT_W),
    .DB_CYCLES(DB)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .step_btn (step_btn),
    .load     (load),
    .pattern  (pattern),
    .w        (w),
    .w_valid  (w_valid),
    .bits_left(bits_left),
    .busy     (busy),
    .done     (done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit flip;
    if (Reset) begin
      m_s1 = 1; m_s2 = 1; m_lvl = 1; m_press = 0;
      m_w = 0; m_wv = 0; m_phase = 0;
      m_q.delete(); m_hist.delete();
    end else begin
      m_wv = 0;
      if (load) begin
        m_q.delete();
        for (int i = PAT_W - 1; i >= 0; i--) m_q.push_back(pattern[i]);
        m_phase = 1;
      end else if (m_phase == 1 && m_press) begin
        m_w  = m_q.pop_front();
        m_wv = 1;
        if (m_q.size() == 0) m_phase = 2;
      end
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      flip = (m_hist.size() == DB);
      foreach (m_hist[j]) if (m_hist[j] == m_lvl) flip = 0;
      m_press = 0;
      if (flip) begin
        m_lvl   = !m_lvl;
        m_press = !m_lvl;
      end
      m_s2 = m_s1;
      m_s1 = step_btn;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock);
    @(negedge Clock);
    check("w", w, m_w);
    check("w_valid", w_valid, m_wv);
    check("bits_left", bits_left, m_q.size());
    check("busy", busy, m_phase == 1);
    check("done", done, m_phase == 2);
    if (w_valid === 1'b1) seen.push_back(w);
  endtask

  task automatic hold(input logic v, input int n);
    step_btn = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [7:0] pat);
    load = 1; pattern = pat;
    tick();
    load = 0;
  endtask

  task automatic do_press(input int lo, input int hi, input int load_at,
                          input logic [7:0] pat, output int lat);
    lat = 0;
    for (int i = 1; i <= lo + hi; i++) begin
      step_btn = (i <= lo) ? 1'b0 : 1'b1;
      load = (i == load_at);
      if (i == load_at) pattern = pat;
      tick();
      if (w_valid === 1'b1 && lat == 0) lat = i;
    end
    load = 0;
  endtask

  initial begin
    int lat;
    int n0;
    logic [7:0] p;
    logic [7:0] exp_bits;
    Reset = 1; step_btn = 1; load = 0; pattern = '0;
    @(negedge Clock);
    tick(); tick();
    check("rst_w", w, 0);
    check("rst_busy", busy, 0);
    check("rst_bits_left", bits_left, 0);
    Reset = 0;
    hold(1, 3);

    // Presses in IDLE do nothing.
    for (int k = 0; k < 3; k++) do_press(8, 12, 0, 8'h00, lat);
    check("idle_no_valid", seen.size(), 0);
    check("idle_w", w, 0);

    // Full stream with latency measurement.
    exp_bits = 8'b1011_0001;
    do_load(exp_bits);
    for (int k = 0; k < 8; k++) begin
      do_press(8, 12, 0, 8'h00, lat);
      check("press_latency", lat, 7);
    end
    check("stream_count", seen.size(), 8);
    for (int k = 0; k < 8; k++) check("stream_bit", seen[k], exp_bits[7-k]);
    check("stream_done", done, 1);

    // Bounce behaviour while running.
    do_load($urandom);
    n0 = seen.size();
    hold(0, 3); hold(1, 1); hold(0, 3); hold(1, 10);
    check("bounce_none", seen.size(), n0);
    hold(0, 5); hold(1, 2); hold(0, 1); hold(1, 12);
    check("bounce_one", seen.size(), n0 + 1);

    // Reload in the same cycle as a press.
    p = 8'($urandom) | 8'h20;
    do_load(p);
    for (int k = 0; k < 3; k++) do_press(8, 12, 0, 8'h00, lat);
    n0 = seen.size();
    do_press(8, 12, 7, 8'hFF, lat);
    check("reload_no_valid", seen.size(), n0);
    check("reload_w_kept", w, 1);
    check("reload_left", bits_left, 8);
    for (int k = 0; k < 8; k++) do_press(8, 12, 0, 8'h00, lat);
    check("reload_count", seen.size(), n0 + 8);
    for (int k = 0; k < 8; k++) check("reload_bit", seen[n0+k], 1);

    // DONE hold then reload.
    n0 = seen.size();
    for (int k = 0; k < 2; k++) do_press(8, 12, 0, 8'h00, lat);
    check("done_no_valid", seen.size(), n0);
    check("done_w_hold", w, 1);
    do_load(8'h00);
    check("done_reload_busy", busy, 1);
    check("done_reload_done", done, 0);
    check("done_reload_left", bits_left, 8);

    // Reset mid-run with the key held.
    p = 8'($urandom);
    do_load(p);
    for (int k = 0; k < 4; k++) do_press(8, 12, 0, 8'h00, lat);
    hold(0, 3);
    Reset = 1;
    tick();
    Reset = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_left", bits_left, 0);
    check("mid_rst_w", w, 0);
    n0 = seen.size();
    hold(0, 10); hold(1, 12);
    check("mid_rst_ignored", seen.size(), n0);
    do_load(p);
    do_press(8, 12, 0, 8'h00, lat);
    check("mid_rst_count", seen.size(), n0 + 1);
    check("mid_rst_first", w, p[7]);

    // Random traffic.
    for (int it = 0; it < 120; it++) begin
      int r;
      int lo;
      int hi;
      r = $urandom_range(0, 19);
      if (r < 3) begin
        do_load($urandom);
      end else if (r == 3) begin
        Reset = 1; tick(); Reset = 0;
      end else begin
        lo = $urandom_range(1, 9);
        hi = $urandom_range(1, 12);
        do_press(lo, hi, ($urandom_range(0, 5) == 0) ? $urandom_range(1, lo + hi) : 0,
                 $urandom, lat);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
